// File: rtl/sort_stream_tx.sv
// sort_stream_tx: reads a packet from a dual-port RAM read port and streams it
// to the sort receiver as one sop..eop packet, honouring snk_ready backpressure.
// A 2-entry skid FIFO absorbs the 1-cycle RAM read latency.
// Optional build macro SORT_TX_GAP_EN: hold GAP_CYCLES idle cycles after each
// packet before accepting the next command (default build: single-cycle gap).
module sort_stream_tx #(
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_LENGTH = 256,
    parameter  int GAP_CYCLES = 4,
    localparam int ADDR_WIDTH = $clog2(MAX_LENGTH)
) (
    input  logic                  snk_clock,
    input  logic                  snk_reset,
    input  logic                  cmd_valid,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] buf_rdaddress,
    output logic                  buf_rden,
    input  logic [DATA_WIDTH-1:0] buf_q,
    output logic [DATA_WIDTH-1:0] snk_data,
    output logic                  snk_sop,
    output logic                  snk_eop,
    output logic                  snk_valid,
    input  logic                  snk_ready,
    output logic                  tx_done,
    output logic                  cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [ADDR_WIDTH-1:0] r_txCnt;
    logic                  r_rdDone;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_fifoWr;
    logic                  r_fifoRd;
    logic [1:0]            r_fifoCount;
    logic                  r_txDone;
    logic                  r_cmdErr;

    logic                  w_cmdAccept;
    logic                  w_rden;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_eopXfer;
    logic                  w_gapDone;
    logic [1:0]            w_used;

    // Stream side: FIFO head is the beat on offer; sop/eop come from the beat counter
    assign snk_valid     = (r_fifoCount != 2'd0);
    assign snk_data      = r_fifo[r_fifoRd];
    assign snk_sop       = snk_valid && (r_txCnt == '0);
    assign snk_eop       = snk_valid && (r_txCnt == r_len);
    assign w_pop         = snk_valid && snk_ready;
    assign w_push        = r_inflight;
    assign w_eopXfer     = w_pop && snk_eop;
    assign buf_rden      = w_rden;
    assign buf_rdaddress = r_rdPtr;
    assign tx_done       = r_txDone;
    assign cmd_err       = r_cmdErr;

    // Slots that will be occupied next cycle; a beat leaving this cycle frees its slot
    // immediately so the read pipeline sustains one word per cycle.
    assign w_used = r_fifoCount + {1'b0, r_inflight} - {1'b0, w_pop};

`ifdef SORT_TX_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    logic [GAP_W-1:0] r_gapCnt;

    // Gap counter: counts cycles spent in ST_GAP, cleared everywhere else
    always_ff @(posedge snk_clock or posedge snk_reset) begin
        if (snk_reset) begin
            r_gapCnt <= '0;
        end else if (r_state != ST_GAP) begin
            r_gapCnt <= '0;
        end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
        end
    end

    assign w_gapDone = ((int'(r_gapCnt) + 1) >= GAP_CYCLES);
`else
    // Without the gap feature ST_GAP lasts a single cycle regardless of GAP_CYCLES
    assign w_gapDone = (GAP_CYCLES >= 0);
`endif

    // State register
    always_ff @(posedge snk_clock or posedge snk_reset) begin
        if (snk_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus command handshake and read-issue decision
    always_comb begin
        w_nextState = r_state;
        w_cmdAccept = 1'b0;
        w_rden      = 1'b0;
        cmd_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_cmdAccept = 1'b1;
                    if (cmd_len != '0) begin
                        w_nextState = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                w_rden = !r_rdDone && (w_used < 2'd2);
                if (w_eopXfer) begin
                    w_nextState = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gapDone) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Packet bookkeeping: length latch, read pointer (stops at len), beat counter, pulses
    always_ff @(posedge snk_clock or posedge snk_reset) begin
        if (snk_reset) begin
            r_len      <= '0;
            r_rdPtr    <= '0;
            r_rdDone   <= 1'b0;
            r_txCnt    <= '0;
            r_inflight <= 1'b0;
            r_txDone   <= 1'b0;
            r_cmdErr   <= 1'b0;
        end else begin
            r_inflight <= w_rden;
            r_txDone   <= w_eopXfer;
            r_cmdErr   <= w_cmdAccept && (cmd_len == '0);
            if (w_cmdAccept) begin
                r_len    <= cmd_len;
                r_rdPtr  <= '0;
                r_rdDone <= 1'b0;
                r_txCnt  <= '0;
            end else begin
                if (w_rden) begin
                    if (r_rdPtr == r_len) begin
                        r_rdDone <= 1'b1;
                    end else begin
                        r_rdPtr <= r_rdPtr + 1'b1;
                    end
                end
                if (w_pop) begin
                    r_txCnt <= r_txCnt + 1'b1;
                end
            end
        end
    end

    // Skid FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge snk_clock or posedge snk_reset) begin
        if (snk_reset) begin
            r_fifoWr    <= 1'b0;
            r_fifoRd    <= 1'b0;
            r_fifoCount <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifoWr <= ~r_fifoWr;
            end
            if (w_pop) begin
                r_fifoRd <= ~r_fifoRd;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + 2'd1;
                2'b01:   r_fifoCount <= r_fifoCount - 2'd1;
                default: r_fifoCount <= r_fifoCount;
            endcase
        end
    end

    // Skid FIFO storage captures RAM data the cycle after the read strobe
    always_ff @(posedge snk_clock) begin
        if (w_push) begin
            r_fifo[r_fifoWr] <= buf_q;
        end
    end

endmodule

// File: tb/tb_sort_stream_tx.sv
// tb_sort_stream_tx: self-checking bench for sort_stream_tx with a RAM model,
// a beat scoreboard, table-driven packets and hand-written corner sequences.
`timescale 1ns/1ps
module tb_sort_stream_tx;

    localparam int DW = 16;
    localparam int AW = 8;
`ifdef SORT_TX_GAP_EN
    localparam int EXP_GAP = 4;
`else
    localparam int EXP_GAP = 1;
`endif

    logic          snk_clock = 1'b0;
    logic          snk_reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_len   = '0;
    logic          cmd_ready;
    logic [AW-1:0] buf_rdaddress;
    logic          buf_rden;
    logic [DW-1:0] buf_q     = '0;
    logic [DW-1:0] snk_data;
    logic          snk_sop;
    logic          snk_eop;
    logic          snk_valid;
    logic          snk_ready = 1'b1;
    logic          tx_done;
    logic          cmd_err;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        int len;
        int readyMode;
        int expBeats;
        int expDone;
        int expErr;
    } vec_t;

    logic [DW-1:0] mem [256];
    beat_t         sbQ [$];
    vec_t          vecs [7];

    int checks      = 0;
    int errors      = 0;
    int expAddr     = 0;
    int curLen      = 0;
    int readsIssued = 0;
    int beatsXfer   = 0;
    int doneSeen    = 0;
    int errSeen     = 0;
    int readyMode   = 0;
    int patIdx      = 0;
    logic [5:0] patBits = 6'b101001;

    sort_stream_tx #(
        .DATA_WIDTH(16),
        .MAX_LENGTH(256),
        .GAP_CYCLES(4)
    ) dut (
        .snk_clock    (snk_clock),
        .snk_reset    (snk_reset),
        .cmd_valid    (cmd_valid),
        .cmd_len      (cmd_len),
        .cmd_ready    (cmd_ready),
        .buf_rdaddress(buf_rdaddress),
        .buf_rden     (buf_rden),
        .buf_q        (buf_q),
        .snk_data     (snk_data),
        .snk_sop      (snk_sop),
        .snk_eop      (snk_eop),
        .snk_valid    (snk_valid),
        .snk_ready    (snk_ready),
        .tx_done      (tx_done),
        .cmd_err      (cmd_err)
    );

    always #5 snk_clock = ~snk_clock;

    // RAM model with one cycle of read latency
    always @(posedge snk_clock) begin
        if (buf_rden) begin
            buf_q <= mem[buf_rdaddress];
        end
    end

    // Backpressure driver: always ready, fixed 1,0,0,1,0,1 pattern, or random
    always @(posedge snk_clock) begin
        #1;
        case (readyMode)
            0: snk_ready = 1'b1;
            1: begin
                snk_ready = patBits[patIdx];
                patIdx = (patIdx == 5) ? 0 : patIdx + 1;
            end
            default: snk_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: read addresses, outstanding reads, scoreboard beats, pulses
    always @(negedge snk_clock) begin
        if (!snk_reset) begin
            if (buf_rden) begin
                checks++;
                if (readsIssued - beatsXfer > 2) begin
                    errors++;
                    $display("[TB] FAIL rdOutstanding: got %0d, expected <= 2", readsIssued - beatsXfer);
                end
                checkOutput("rdAddr", buf_rdaddress, expAddr);
                checks++;
                if (expAddr > curLen) begin
                    errors++;
                    $display("[TB] FAIL rdRange: read %0d, expected <= %0d", expAddr, curLen);
                end
                expAddr++;
                readsIssued++;
            end
            if (snk_valid) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedBeat", snk_valid, 0);
                end else begin
                    checkOutput("beatData", snk_data, sbQ[0].data);
                    checkOutput("beatSop", snk_sop, sbQ[0].sop);
                    checkOutput("beatEop", snk_eop, sbQ[0].eop);
                    if (snk_ready) begin
                        void'(sbQ.pop_front());
                        beatsXfer++;
                    end
                end
            end
            if (tx_done) doneSeen++;
            if (cmd_err) errSeen++;
        end
    end

    task automatic applyStimulus(input int len);
        int n = 0;
        @(negedge snk_clock);
        while (!cmd_ready && n < 100) begin
            @(negedge snk_clock);
            n++;
        end
        checkOutput("cmdReadyWait", cmd_ready, 1);
        for (int i = 0; i <= len && len > 0; i++) begin
            sbQ.push_back('{data: mem[i], sop: (i == 0), eop: (i == len)});
        end
        curLen      = len;
        expAddr     = 0;
        readsIssued = 0;
        beatsXfer   = 0;
        doneSeen    = 0;
        errSeen     = 0;
        cmd_len     = AW'(len);
        cmd_valid   = 1'b1;
        @(posedge snk_clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitPacket(input int expBeats, input int expDone, input int expErr);
        int n = 0;
        while (!((doneSeen + errSeen) > 0 && sbQ.size() == 0) && n < 3000) begin
            @(negedge snk_clock);
            n++;
        end
        checkOutput("pktTimeout", n, (n < 3000) ? n : -1);
        repeat (6) @(negedge snk_clock);
        checkOutput("beatCount", beatsXfer, expBeats);
        checkOutput("txDoneCount", doneSeen, expDone);
        checkOutput("cmdErrCount", errSeen, expErr);
        checkOutput("queueLeft", sbQ.size(), 0);
        checkOutput("cmdReadyIdle", cmd_ready, 1);
    endtask

    initial begin
        int n;
        int low;

        for (int i = 0; i < 256; i++) mem[i] = DW'(i * 37 + 5);
        mem[0] = 16'd9;
        mem[1] = 16'd3;
        mem[2] = 16'd7;
        mem[3] = 16'd1;

        vecs[0] = '{len: 3,   readyMode: 0, expBeats: 4,   expDone: 1, expErr: 0};
        vecs[1] = '{len: 3,   readyMode: 1, expBeats: 4,   expDone: 1, expErr: 0};
        vecs[2] = '{len: 0,   readyMode: 0, expBeats: 0,   expDone: 0, expErr: 1};
        vecs[3] = '{len: 255, readyMode: 0, expBeats: 256, expDone: 1, expErr: 0};
        vecs[4] = '{len: 1,   readyMode: 2, expBeats: 2,   expDone: 1, expErr: 0};
        vecs[5] = '{len: 17,  readyMode: 2, expBeats: 18,  expDone: 1, expErr: 0};
        vecs[6] = '{len: 255, readyMode: 1, expBeats: 256, expDone: 1, expErr: 0};

        // Reset state
        #2 snk_reset = 1'b1;
        repeat (3) @(posedge snk_clock);
        #1;
        checkOutput("rstValid", snk_valid, 0);
        checkOutput("rstRden", buf_rden, 0);
        checkOutput("rstSop", snk_sop, 0);
        checkOutput("rstEop", snk_eop, 0);
        checkOutput("rstTxDone", tx_done, 0);
        checkOutput("rstCmdErr", cmd_err, 0);
        checkOutput("rstAddr", buf_rdaddress, 0);
        #1 snk_reset = 1'b0;
        @(negedge snk_clock);
        checkOutput("rstCmdReady", cmd_ready, 1);

        // Table-driven packets
        for (int v = 0; v < 7; v++) begin
            readyMode = vecs[v].readyMode;
            applyStimulus(vecs[v].len);
            waitPacket(vecs[v].expBeats, vecs[v].expDone, vecs[v].expErr);
        end
        readyMode = 0;

        // Latency: first read the cycle after accept, first valid two edges after accept
        applyStimulus(3);
        checkOutput("firstRden", buf_rden, 1);
        checkOutput("noEarlyValid", snk_valid, 0);
        n = 0;
        while (!snk_valid && n < 20) begin
            @(posedge snk_clock);
            #1;
            n++;
        end
        checkOutput("firstValidLatency", n, 2);
        waitPacket(4, 1, 0);

        // Gap length after tx_done, then a back-to-back command
        applyStimulus(3);
        n = 0;
        @(negedge snk_clock);
        while (!tx_done && n < 200) begin
            @(negedge snk_clock);
            n++;
        end
        checkOutput("gapTxDoneSeen", tx_done, 1);
        low = 0;
        while (!cmd_ready && low < 50) begin
            low++;
            @(negedge snk_clock);
        end
        checkOutput("gapCmdReadyLow", low, EXP_GAP);
        applyStimulus(5);
        waitPacket(6, 1, 0);

        // Reset in the middle of a 10-word packet
        applyStimulus(9);
        n = 0;
        while (beatsXfer < 5 && n < 200) begin
            @(negedge snk_clock);
            n++;
        end
        checkOutput("midBeatsReached", beatsXfer >= 5, 1);
        @(posedge snk_clock);
        #2 snk_reset = 1'b1;
        #1;
        checkOutput("midRstValid", snk_valid, 0);
        checkOutput("midRstRden", buf_rden, 0);
        checkOutput("midRstCmdReady", cmd_ready, 1);
        checkOutput("midRstNoEop", doneSeen, 0);
        sbQ.delete();
        readsIssued = 0;
        beatsXfer   = 0;
        @(posedge snk_clock);
        @(posedge snk_clock);
        #2 snk_reset = 1'b0;
        applyStimulus(9);
        waitPacket(10, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
